// File: rtl/shift_wb_buffer.sv
// shift_wb_buffer: two-entry in-order writeback buffer sitting behind the
// execute-stage ALUs. Results are retired to the register-file write port
// and update the Z/N flags on retirement. Decode can look up a combinational
// forwarding path into the buffered results.
module shift_wb_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_setf,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data,
    output logic [15:0]       retired
);
    // DEPTH is fixed at 2: a 1-bit pointer wraps naturally.
    localparam int PTR_W = 1;

    logic [DEPTH-1:0][DATA_W-1:0] result_reg;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_reg;
    logic [DEPTH-1:0]             we_reg;
    logic [DEPTH-1:0]             setf_reg;

    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             flag_z_reg, flag_z_next;
    logic             flag_n_reg, flag_n_next;
    logic [15:0]      retired_reg, retired_next;

    logic             has_head;
    logic             head_we;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] young_idx;

    // Handshake and retire decisions; in_ready depends only on state.
    always_comb begin
        has_head = (count_reg != '0);
        head_we  = we_reg[head_reg];
        in_ready = reset_n && (count_reg != 2'(DEPTH));
        push     = in_valid && in_ready;
        pop      = has_head && (rf_ready || !head_we);
    end

    // Head entry is presented to the register-file port; zeros when empty.
    always_comb begin
        rf_we    = reset_n && has_head && head_we;
        rf_waddr = has_head ? rd_reg[head_reg] : '0;
        rf_wdata = has_head ? result_reg[head_reg] : '0;
    end

    // Next-state for pointers, occupancy, flags and retire counter.
    always_comb begin
        valid_next   = valid_reg;
        head_next    = head_reg;
        tail_next    = tail_reg;
        count_next   = count_reg;
        flag_z_next  = flag_z_reg;
        flag_n_next  = flag_n_reg;
        retired_next = retired_reg;
        if (push) begin
            tail_next            = tail_reg + 1'b1;
            valid_next[tail_reg] = 1'b1;
        end
        if (pop) begin
            head_next            = head_reg + 1'b1;
            valid_next[head_reg] = 1'b0;
            retired_next         = retired_reg + 16'd1;
            if (setf_reg[head_reg]) begin
                flag_z_next = (result_reg[head_reg] == '0);
                flag_n_next = result_reg[head_reg][DATA_W-1];
            end
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Control state register; reset discards buffered entries silently.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            flag_z_reg  <= 1'b0;
            flag_n_reg  <= 1'b0;
            retired_reg <= '0;
        end else begin
            valid_reg   <= valid_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            count_reg   <= count_next;
            flag_z_reg  <= flag_z_next;
            flag_n_reg  <= flag_n_next;
            retired_reg <= retired_next;
        end
    end

    // Entry payload storage; written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            result_reg[tail_reg] <= in_result;
            rd_reg[tail_reg]     <= in_rd;
            we_reg[tail_reg]     <= in_we;
            setf_reg[tail_reg]   <= in_setf;
        end
    end

    // Per-entry forwarding match: only live, register-writing entries count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && we_reg[gi] && (rd_reg[gi] == q_addr);
        end
    endgenerate

    // Youngest match wins; with two entries the younger one sits opposite the head.
    always_comb begin
        young_idx = head_reg ^ PTR_W'(count_reg[PTR_W]);
        q_hit     = |match;
        if (match[young_idx]) begin
            q_data = result_reg[young_idx];
        end else if (match[head_reg]) begin
            q_data = result_reg[head_reg];
        end else begin
            q_data = '0;
        end
    end

    assign flag_z  = flag_z_reg;
    assign flag_n  = flag_n_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_shift_wb_buffer.sv
// Self-checking bench for shift_wb_buffer: directed scenarios plus a random
// run, all compared against a queue-based model of the writeback buffer.
module tb_shift_wb_buffer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        in_setf;
    logic        rf_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_z;
    logic        flag_n;
    logic [2:0]  q_addr;
    logic        q_hit;
    logic [15:0] q_data;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    shift_wb_buffer #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_rd(in_rd), .in_we(in_we), .in_setf(in_setf),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_z(flag_z), .flag_n(flag_n),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .retired(retired)
    );

    always #5 clk = ~clk;

    // Reference model: an in-order queue of at most two entries.
    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  rd;
        logic        we;
        logic        setf;
    } ent_t;

    ent_t        mq[$];
    logic        m_z   = 1'b0;
    logic        m_n   = 1'b0;
    logic [15:0] m_ret = 16'd0;

    function automatic logic [16:0] m_fwd(input logic [2:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].we && mq[i].rd == a) return {1'b1, mq[i].res};
        return 17'd0;
    endfunction

    function automatic logic m_rf_we();
        return (mq.size() > 0) && mq[0].we;
    endfunction

    function automatic logic [2:0] m_waddr();
        return (mq.size() > 0) ? mq[0].rd : 3'd0;
    endfunction

    function automatic logic [15:0] m_wdata();
        return (mq.size() > 0) ? mq[0].res : 16'd0;
    endfunction

    // Advance one clock edge, applying the same inputs to the model.
    task automatic tick();
        bit   do_pop, do_push;
        ent_t e, ni;
        do_pop  = reset_n && (mq.size() > 0) && (rf_ready || !mq[0].we);
        do_push = reset_n && in_valid && (mq.size() < 2);
        ni      = '{res: in_result, rd: in_rd, we: in_we, setf: in_setf};
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
            m_z = 1'b0; m_n = 1'b0; m_ret = 16'd0;
        end else begin
            if (do_pop) begin
                e = mq.pop_front();
                m_ret = m_ret + 16'd1;
                if (e.setf) begin
                    m_z = (e.res == 16'd0);
                    m_n = e.res[15];
                end
            end
            if (do_push) mq.push_back(ni);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] rd,
                         input logic we, input logic sf);
        in_valid = v; in_result = r; in_rd = rd; in_we = we; in_setf = sf;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rf_ready = 1'b0; q_addr = 3'd0;
        drive(1'b0, 16'd0, 3'd0, 1'b0, 1'b0);
        tick(); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        tick();
        reset_n = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        total++; if ({flag_z, flag_n} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", flag_z, flag_n); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        rf_ready = 1'b1;
        drive(1'b1, 16'h0010, 3'd3, 1'b1, 1'b1); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b exp=0", rf_we); end
        tick();
        drive(1'b0, 16'd0, 3'd0, 1'b0, 1'b0); #1;
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 16'h0010})
            begin bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/0010", rf_we, rf_waddr, rf_wdata); end
        tick(); #1;
        total++; if ({flag_z, flag_n, retired} !== {2'b00, 16'd1})
            begin bad++; $display("FAIL single_retire got=z%b n%b r%0d exp=z0 n0 r1", flag_z, flag_n, retired); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_empty_rf_we got=%b exp=0", rf_we); end
        $display("test_single done");
    endtask

    task automatic test_backpressure();
        rf_ready = 1'b0;
        drive(1'b1, 16'h8000, 3'd1, 1'b1, 1'b1); tick();
        drive(1'b1, 16'h0000, 3'd2, 1'b1, 1'b1); tick();
        drive(1'b1, 16'h5555, 3'd6, 1'b1, 1'b1); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
        tick(); #1;
        total++; if ({in_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 3'd1, 16'h8000})
            begin bad++; $display("FAIL bp_hold got=%b/%b/%0d/%h exp=0/1/1/8000", in_ready, rf_we, rf_waddr, rf_wdata); end
        drive(1'b0, 16'd0, 3'd0, 1'b0, 1'b0); rf_ready = 1'b1;
        tick(); #1;
        total++; if ({rf_waddr, rf_wdata, flag_z, flag_n, in_ready} !== {3'd2, 16'h0000, 1'b0, 1'b1, 1'b1})
            begin bad++; $display("FAIL bp_second got=%0d/%h z%b n%b rdy%b exp=2/0000 z0 n1 rdy1", rf_waddr, rf_wdata, flag_z, flag_n, in_ready); end
        tick(); #1;
        total++; if ({flag_z, flag_n, rf_we} !== 3'b100)
            begin bad++; $display("FAIL bp_final got=z%b n%b we%b exp=z1 n0 we0", flag_z, flag_n, rf_we); end
        total++; if (retired !== 16'd3) begin bad++; $display("FAIL bp_retired got=%0d exp=3", retired); end
        $display("test_backpressure done");
    endtask

    task automatic test_forwarding();
        rf_ready = 1'b0;
        drive(1'b1, 16'h1234, 3'd5, 1'b1, 1'b0); tick();
        drive(1'b1, 16'hBEEF, 3'd5, 1'b1, 1'b0); tick();
        drive(1'b0, 16'd0, 3'd0, 1'b0, 1'b0);
        q_addr = 3'd5; #1;
        total++; if ({q_hit, q_data} !== {1'b1, 16'hBEEF})
            begin bad++; $display("FAIL fwd_young got=%b/%h exp=1/beef", q_hit, q_data); end
        q_addr = 3'd4; #1;
        total++; if ({q_hit, q_data} !== {1'b0, 16'h0000})
            begin bad++; $display("FAIL fwd_miss got=%b/%h exp=0/0000", q_hit, q_data); end
        rf_ready = 1'b1; q_addr = 3'd5; #1;
        total++; if ({q_hit, q_data} !== {1'b1, 16'hBEEF})
            begin bad++; $display("FAIL fwd_retiring got=%b/%h exp=1/beef", q_hit, q_data); end
        tick(); tick(); #1;
        total++; if (q_hit !== 1'b0) begin bad++; $display("FAIL fwd_drained got=%b exp=0", q_hit); end
        $display("test_forwarding done");
    endtask

    task automatic test_nonwrite();
        logic [15:0] r0;
        rf_ready = 1'b0;
        drive(1'b1, 16'hFFF0, 3'd7, 1'b0, 1'b1); tick();
        r0 = m_ret;
        drive(1'b0, 16'd0, 3'd0, 1'b0, 1'b0); q_addr = 3'd7; #1;
        total++; if ({rf_we, q_hit} !== 2'b00)
            begin bad++; $display("FAIL nw_no_write got=we%b hit%b exp=we0 hit0", rf_we, q_hit); end
        tick(); #1;
        total++; if ({flag_n, flag_z, in_ready} !== 3'b101)
            begin bad++; $display("FAIL nw_flags got=n%b z%b rdy%b exp=n1 z0 rdy1", flag_n, flag_z, in_ready); end
        total++; if (retired !== r0 + 16'd1)
            begin bad++; $display("FAIL nw_retired got=%0d exp=%0d", retired, r0 + 16'd1); end
        $display("test_nonwrite done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] r0;
        rf_ready = 1'b1;
        drive(1'b1, 16'($urandom), 3'($urandom), 1'b1, 1'b1); tick();
        r0 = m_ret;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'($urandom), 3'($urandom), 1'b1, 1'($urandom)); #1;
            total++; if ({in_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, m_waddr(), m_wdata()})
                begin bad++; $display("FAIL b2b_%0d got=%b/%b/%0d/%h exp=1/1/%0d/%h", i, in_ready, rf_we, rf_waddr, rf_wdata, m_waddr(), m_wdata()); end
            tick();
        end
        #1;
        total++; if (retired !== r0 + 16'd10)
            begin bad++; $display("FAIL b2b_retired got=%0d exp=%0d", retired, r0 + 16'd10); end
        drive(1'b0, 16'd0, 3'd0, 1'b0, 1'b0); tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        logic [16:0] f;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 16'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0),
                  1'($urandom));
            if ($urandom_range(0, 7) == 0) in_result = 16'd0;
            rf_ready = 1'($urandom);
            q_addr   = 3'($urandom);
            #1;
            f = m_fwd(q_addr);
            total++;
            if ({in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, flag_z, flag_n, retired} !==
                {(mq.size() < 2), m_rf_we(), m_waddr(), m_wdata(), f, m_z, m_n, m_ret}) begin
                bad++;
                $display("FAIL rand_%0d got rdy%b we%b a%0d d%h hit%b q%h z%b n%b r%0d exp rdy%b we%b a%0d d%h hit%b q%h z%b n%b r%0d",
                         i, in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, flag_z, flag_n, retired,
                         (mq.size() < 2), m_rf_we(), m_waddr(), m_wdata(), f[16], f[15:0], m_z, m_n, m_ret);
            end
            tick();
        end
        $display("test_random done");
    endtask

    task automatic test_midreset();
        rf_ready = 1'b0;
        drive(1'b1, 16'h8001, 3'd4, 1'b1, 1'b1); tick();
        drive(1'b1, 16'h7002, 3'd4, 1'b1, 1'b1); tick();
        drive(1'b0, 16'd0, 3'd0, 1'b0, 1'b0); reset_n = 1'b0; q_addr = 3'd4; #1;
        total++; if ({in_ready, rf_we} !== 2'b00)
            begin bad++; $display("FAIL mr_during got=rdy%b we%b exp=rdy0 we0", in_ready, rf_we); end
        tick();
        reset_n = 1'b1; #1;
        total++; if ({rf_we, flag_z, flag_n, retired, in_ready, q_hit} !== {3'b000, 16'd0, 1'b1, 1'b0})
            begin bad++; $display("FAIL mr_after got=we%b z%b n%b r%0d rdy%b hit%b exp=we0 z0 n0 r0 rdy1 hit0", rf_we, flag_z, flag_n, retired, in_ready, q_hit); end
        $display("test_midreset done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_forwarding();
        test_nonwrite();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
